// File: rtl/fetch_buffer.sv
// Circular FIFO between instruction fetch and decode: all-or-nothing packet push, up to
// DECODE_WIDTH oldest entries popped per cycle. FETCH_BUFFER_PERF_EN adds stall/empty counters.
module fetch_buffer #(
  parameter int FB_DEPTH     = 16,
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int ENTRY_W      = 32
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset,
  input  logic                                   i_flush,
  input  logic [FETCH_WIDTH-1:0][ENTRY_W-1:0]    i_insts_in,
  input  logic                                   i_insts_in_valid,
  output logic                                   o_stall_out,
  output logic [DECODE_WIDTH-1:0][ENTRY_W-1:0]   o_insts_out,
  output logic [DECODE_WIDTH-1:0]                o_insts_out_valid,
  input  logic                                   i_decode_ready,
  output logic                                   o_overflow_err
`ifdef FETCH_BUFFER_PERF_EN
  ,
  output logic [31:0]                            o_perf_stall_cycles,
  output logic [31:0]                            o_perf_empty_cycles
`endif
);

  localparam int PTR_W = $clog2(FB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FB_DEPTH);
  localparam logic [CNT_W-1:0] FW_C    = CNT_W'(FETCH_WIDTH);
  localparam logic [CNT_W-1:0] DW_C    = CNT_W'(DECODE_WIDTH);
  localparam logic [CNT_W-1:0] STALL_C = CNT_W'(2 * FETCH_WIDTH);

  logic [ENTRY_W-1:0] r_mem [FB_DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow_err;

  logic [CNT_W-1:0]   w_free;
  logic [CNT_W-1:0]   w_pop_n;
  logic [CNT_W-1:0]   w_free_after_pop;
  logic [CNT_W-1:0]   w_count_next;
  logic               w_push;
  logic               w_drop;

  assign w_free           = DEPTH_C - r_count;
  // Margin of two packets covers the one already in flight while fetch reacts.
  assign o_stall_out      = (w_free < STALL_C);
  assign w_pop_n          = !i_decode_ready ? '0 : ((r_count < DW_C) ? r_count : DW_C);
  assign w_free_after_pop = w_free + w_pop_n;
  assign w_push           = i_insts_in_valid && (w_free_after_pop >= FW_C);
  assign w_drop           = i_insts_in_valid && !w_push;
  assign w_count_next     = r_count + (w_push ? FW_C : '0) - w_pop_n;
  assign o_overflow_err   = r_overflow_err;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_overflow_err <= 1'b0;
    end else begin
      if (i_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + PTR_W'(w_pop_n);
        r_tail  <= r_tail + (w_push ? PTR_W'(FETCH_WIDTH) : '0);
        r_count <= w_count_next;
      end
      if (w_drop) begin
        r_overflow_err <= 1'b1;
      end
    end
  end

  // Entry storage is intentionally not reset; validity is tracked solely by r_count.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        r_mem[r_tail + PTR_W'(i)] <= i_insts_in[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DECODE_WIDTH; gi++) begin : g_out
      assign o_insts_out[gi]       = r_mem[r_head + PTR_W'(gi)];
      assign o_insts_out_valid[gi] = (CNT_W'(gi) < r_count);
    end
  endgenerate

`ifdef FETCH_BUFFER_PERF_EN
  logic [31:0] r_perf_stall_cycles;
  logic [31:0] r_perf_empty_cycles;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_perf_stall_cycles <= '0;
      r_perf_empty_cycles <= '0;
    end else begin
      if (o_stall_out && (r_perf_stall_cycles != 32'hFFFF_FFFF)) begin
        r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
      end
      if ((r_count == '0) && (r_perf_empty_cycles != 32'hFFFF_FFFF)) begin
        r_perf_empty_cycles <= r_perf_empty_cycles + 32'd1;
      end
    end
  end

  assign o_perf_stall_cycles = r_perf_stall_cycles;
  assign o_perf_empty_cycles = r_perf_empty_cycles;
`endif

endmodule
